redmule_fetch_ctrl: RTL and testbench
=====================================

Name: redmule_fetch_ctrl

Overview:
Device-side counterpart of the simulation clock/reset/fetch-enable driver. Consumes the raw fetch_enable level after the reset sequence and releases the RedMulE subsystem fetch enable deterministically. Watches the subsystem for end-of-computation and exposes done, exit code, timeout and a cycle count to the bench or SoC.

Parameters:
PostRstCycles, 16, cycles to wait after reset release before fetch_enable_i is honoured; 0 means arm on the first cycle.
TimeoutCycles, 100000, run-cycle limit before a forced timeout termination; must be >= 1.
CntWidth, 32, width of the run-cycle counter.
ExitWidth, 32, width of the exit code.

Ports:
clk_i  in  1  clock, single domain
rst_ni  in  1  asynchronous active-low reset
fetch_enable_i  in  1  raw fetch-enable level, may be asynchronous to clk_i
core_fetch_en_o  out  1  fetch enable to the RedMulE subsystem
start_o  out  1  one-cycle pulse on the first RUNNING cycle
exit_valid_i  in  1  subsystem end-of-computation strobe
exit_code_i  in  ExitWidth  exit code, qualified by exit_valid_i
done_o  out  1  run finished; sticky until reset
timeout_o  out  1  run terminated by timeout; sticky until reset
exit_code_o  out  ExitWidth  latched exit code
cycle_cnt_o  out  CntWidth  RUNNING cycle count

Behaviour:
- Reset: all state asynchronously cleared. State is RST_WAIT. All outputs are 0.
- Synchronizer: fetch_enable_i goes through a 2-flop synchronizer that resets to 0. The synchronized value fe_s lags the input by 2 rising edges.
- FSM states: RST_WAIT, ARMED, RUNNING, DONE.
- RST_WAIT:
  - Wait counter increments each cycle starting at 0.
  - When wait counter == PostRstCycles-1, go to ARMED. With PostRstCycles = 0, go to ARMED after one cycle.
  - fe_s is ignored in this state.
- ARMED: fe_s == 1 -> RUNNING. A level already high at arming counts as an enable.
- RUNNING:
  - core_fetch_en_o = 1 (registered; high from the first RUNNING cycle).
  - start_o = 1 only on the first RUNNING cycle.
  - cycle_cnt_o = 0 on the first RUNNING cycle, then increments by 1 per cycle, saturating at all-ones.
  - fe_s falling is ignored: the enable is sticky for the run.
  - exit_valid_i == 1 -> DONE. exit_code_o <= exit_code_i.
  - cycle_cnt_o == TimeoutCycles-1 with no exit_valid_i -> DONE. timeout_o <= 1, exit_code_o <= all-ones.
  - Simultaneous exit_valid_i and timeout: exit wins, timeout_o stays 0.
- DONE:
  - Terminal until reset.
  - core_fetch_en_o = 0, done_o = 1.
  - cycle_cnt_o frozen.
  - Further exit_valid_i ignored; exit_code_o is not overwritten.
- exit_valid_i outside RUNNING is ignored.
- Reset asserted mid-run: immediate return to RST_WAIT with outputs 0. After release, the full PostRstCycles wait applies again. This covers the double-reset sequence.
- done_o, timeout_o, exit_code_o and core_fetch_en_o are registered outputs. start_o is decoded from the state register.

Decomposition:
- redmule_pkg gains typedef enum logic [1:0] fetch_ctrl_state_e {RST_WAIT, ARMED, RUNNING, DONE}.
- redmule_pkg gains localparam FetchCtrlTimeoutCode (all-ones, ExitWidth).
- Synchronizer is the common_cells sync instance (STAGES=2, ResetValue 0). It is the one sub-module; no custom CDC.
- FSM, wait counter and run counter are inline.

Test Plan:
1. Reset 20 cycles, release, fetch_enable_i=1 at cycle 5 after release, PostRstCycles=16 -> ARMED at cycle 16. RUNNING and start_o pulse (exactly 1 cycle) at cycle 17 or later. core_fetch_en_o high from that cycle.
2. Release, 10 cycles, reset again for 10, release, fetch_enable at +100 cycles -> no RUNNING before second release + 16. Start occurs 2–3 cycles after the enable edge.
3. RUNNING 50 cycles, exit_valid_i=1 with exit_code_i=0x0000_0000 -> next cycle done_o=1, timeout_o=0, exit_code_o=0, cycle_cnt_o=50, core_fetch_en_o=0.
4. TimeoutCycles=64, no exit -> done_o=1 and timeout_o=1 after cycle_cnt_o hits 63. exit_code_o=0xFFFF_FFFF.
5. TimeoutCycles=64, exit_valid_i with code 0x2A on the cycle cycle_cnt_o==63 -> timeout_o=0, exit_code_o=0x2A.
6. Drop fetch_enable_i mid-run, pulse exit_valid_i again after DONE with code 0x5 -> core_fetch_en_o stays 1 until the first exit. exit_code_o unchanged by the second pulse. Assert rst_ni in DONE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/redmule_pkg.sv
// ==== redmule_pkg : shared types and constants for the RedMulE fetch controller (rev 1.0) ====
`default_nettype none

package redmule_pkg;

   typedef enum logic [1:0] {
      RST_WAIT = 2'd0,
      ARMED    = 2'd1,
      RUNNING  = 2'd2,
      DONE     = 2'd3
   } fetch_ctrl_state_e;

   localparam int unsigned FetchCtrlExitWidth = 32;

   // Exit code reported when a run is cut short by the cycle limit.
   localparam logic [FetchCtrlExitWidth-1:0] FetchCtrlTimeoutCode = '1;

endpackage

`default_nettype wire

// File: rtl/sync.sv
// ==== sync : multi-stage level synchronizer with asynchronous reset (rev 1.0) ====
`default_nettype none

module sync #(
   parameter int unsigned STAGES     = 2,
   parameter bit          ResetValue = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic serial_i,
   output logic serial_o
);

   logic [STAGES-1:0] reg_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         reg_q <= {STAGES{ResetValue}};
      end else begin
         reg_q <= {reg_q[STAGES-2:0], serial_i};
      end
   end

   assign serial_o = reg_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/redmule_fetch_ctrl.sv
// ==== redmule_fetch_ctrl : post-reset fetch-enable release and end-of-run monitor (rev 1.0) ====
`default_nettype none

module redmule_fetch_ctrl
   import redmule_pkg::*;
#(
   parameter int unsigned PostRstCycles = 16,
   parameter int unsigned TimeoutCycles = 100000,
   parameter int unsigned CntWidth      = 32,
   parameter int unsigned ExitWidth     = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 fetch_enable_i,
   output logic                 core_fetch_en_o,
   output logic                 start_o,
   input  logic                 exit_valid_i,
   input  logic [ExitWidth-1:0] exit_code_i,
   output logic                 done_o,
   output logic                 timeout_o,
   output logic [ExitWidth-1:0] exit_code_o,
   output logic [CntWidth-1:0]  cycle_cnt_o
);

   localparam int unsigned WaitWidth = (PostRstCycles > 2) ? $clog2(PostRstCycles) : 1;
   // A zero wait collapses onto a last count of 0, so arming still takes exactly one cycle.
   localparam logic [WaitWidth-1:0] WaitLast =
      (PostRstCycles > 0) ? WaitWidth'(PostRstCycles - 1) : '0;
   localparam logic [CntWidth-1:0]  TimeoutLast = CntWidth'(TimeoutCycles - 1);
   localparam logic [ExitWidth-1:0] TimeoutCode = {ExitWidth{FetchCtrlTimeoutCode[0]}};

   logic fe_s;

   fetch_ctrl_state_e      state_q, state_d;
   logic [WaitWidth-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CntWidth-1:0]    cycle_cnt_q, cycle_cnt_d;
   logic                   core_fetch_en_q, core_fetch_en_d;
   logic                   done_q, done_d;
   logic                   timeout_q, timeout_d;
   logic [ExitWidth-1:0]   exit_code_q, exit_code_d;

   sync #(
      .STAGES     (2),
      .ResetValue (1'b0)
   ) i_fe_sync (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .serial_i (fetch_enable_i),
      .serial_o (fe_s)
   );

   always_comb begin
      state_d         = state_q;
      wait_cnt_d      = wait_cnt_q;
      cycle_cnt_d     = cycle_cnt_q;
      core_fetch_en_d = core_fetch_en_q;
      done_d          = done_q;
      timeout_d       = timeout_q;
      exit_code_d     = exit_code_q;

      case (state_q)
         RST_WAIT: begin
            if (wait_cnt_q == WaitLast) begin
               state_d = ARMED;
            end else begin
               wait_cnt_d = wait_cnt_q + WaitWidth'(1);
            end
         end

         ARMED: begin
            if (fe_s) begin
               state_d         = RUNNING;
               core_fetch_en_d = 1'b1;
               cycle_cnt_d     = '0;
            end
         end

         RUNNING: begin
            // Saturation also guarantees the zero count (start pulse) is never revisited.
            if (cycle_cnt_q != '1) begin
               cycle_cnt_d = cycle_cnt_q + CntWidth'(1);
            end
            if (exit_valid_i) begin
               state_d         = DONE;
               core_fetch_en_d = 1'b0;
               done_d          = 1'b1;
               exit_code_d     = exit_code_i;
            end else if (cycle_cnt_q == TimeoutLast) begin
               state_d         = DONE;
               core_fetch_en_d = 1'b0;
               done_d          = 1'b1;
               timeout_d       = 1'b1;
               exit_code_d     = TimeoutCode;
            end
         end

         DONE: begin
            state_d = DONE;
         end

         default: begin
            state_d = RST_WAIT;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= RST_WAIT;
         wait_cnt_q      <= '0;
         cycle_cnt_q     <= '0;
         core_fetch_en_q <= 1'b0;
         done_q          <= 1'b0;
         timeout_q       <= 1'b0;
         exit_code_q     <= '0;
      end else begin
         state_q         <= state_d;
         wait_cnt_q      <= wait_cnt_d;
         cycle_cnt_q     <= cycle_cnt_d;
         core_fetch_en_q <= core_fetch_en_d;
         done_q          <= done_d;
         timeout_q       <= timeout_d;
         exit_code_q     <= exit_code_d;
      end
   end

   assign core_fetch_en_o = core_fetch_en_q;
   assign start_o         = (state_q == RUNNING) && (cycle_cnt_q == '0);
   assign done_o          = done_q;
   assign timeout_o       = timeout_q;
   assign exit_code_o     = exit_code_q;
   assign cycle_cnt_o     = cycle_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_redmule_fetch_ctrl.sv
// ==== tb_redmule_fetch_ctrl : scenario table plus randomized runs against a timing model (rev 1.0) ====
`default_nettype none

module tb_redmule_fetch_ctrl;

   localparam int POST = 16;
   localparam int TMO  = 64;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        fetch_enable_i = 1'b0;
   logic        exit_valid_i = 1'b0;
   logic [31:0] exit_code_i = '0;
   logic        core_fetch_en_o;
   logic        start_o;
   logic        done_o;
   logic        timeout_o;
   logic [31:0] exit_code_o;
   logic [31:0] cycle_cnt_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   redmule_fetch_ctrl #(
      .PostRstCycles (POST),
      .TimeoutCycles (TMO),
      .CntWidth      (32),
      .ExitWidth     (32)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .fetch_enable_i  (fetch_enable_i),
      .core_fetch_en_o (core_fetch_en_o),
      .start_o         (start_o),
      .exit_valid_i    (exit_valid_i),
      .exit_code_i     (exit_code_i),
      .done_o          (done_o),
      .timeout_o       (timeout_o),
      .exit_code_o     (exit_code_o),
      .cycle_cnt_o     (cycle_cnt_o)
   );

   // f: first clock edge after release that samples fetch_enable high.
   // k: run-cycle count value during which exit_valid is pulsed (>= TMO means never).
   typedef struct {
      int          f;
      int          k;
      logic [31:0] code;
      bit          drop;
      bit          dbl;
      bit          late_pulse;
      int          exp_r;
      int          exp_cnt;
      bit          exp_to;
      logic [31:0] exp_code;
   } scen_t;

   scen_t tbl[$];

   function automatic scen_t mk(input int f, input int k, input logic [31:0] code,
                                input bit drop, input bit dbl, input bit lp,
                                input int r, input int cnt, input bit to,
                                input logic [31:0] xcode);
      scen_t s;
      s.f = f; s.k = k; s.code = code; s.drop = drop; s.dbl = dbl; s.late_pulse = lp;
      s.exp_r = r; s.exp_cnt = cnt; s.exp_to = to; s.exp_code = xcode;
      return s;
   endfunction

   // Two sync stages delay the enable by two edges; arming needs POST edges, running one more.
   function automatic scen_t model(input int f, input int k, input logic [31:0] code,
                                   input bit drop, input bit dbl, input bit lp);
      int  r;
      int  cnt;
      bit  to;
      r   = (f + 2 > POST + 1) ? f + 2 : POST + 1;
      to  = (k >= TMO);
      cnt = to ? TMO : k + 1;
      return mk(f, k, code, drop, dbl, lp, r, cnt, to, to ? 32'hFFFF_FFFF : code);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic run(input scen_t s);
      int  r;
      int  d;
      bit  exp_run;
      bit  exp_done;
      rst_ni = 1'b0; fetch_enable_i = 1'b0; exit_valid_i = 1'b0; exit_code_i = '0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      if (s.dbl) begin
         for (int i = 0; i < 10; i++) begin
            chk("dbl_core_fetch_en", core_fetch_en_o, 0);
            chk("dbl_start", start_o, 0);
            @(negedge clk);
         end
         rst_ni = 1'b0;
         repeat (10) @(negedge clk);
         chk("dbl_in_reset_done", done_o, 0);
         rst_ni = 1'b1;
      end
      r = s.exp_r;
      d = r + s.exp_cnt;
      for (int n = 0; n <= d + 4; n++) begin
         exp_run  = (n >= r) && (n < d);
         exp_done = (n >= d);
         chk("core_fetch_en", core_fetch_en_o, exp_run);
         chk("start", start_o, n == r);
         chk("done", done_o, exp_done);
         chk("timeout", timeout_o, exp_done && s.exp_to);
         chk("exit_code", exit_code_o, exp_done ? s.exp_code : 32'h0);
         chk("cycle_cnt", cycle_cnt_o, (n < r) ? 0 : (exp_done ? s.exp_cnt : n - r));
         fetch_enable_i = (n + 1 >= s.f) && !(s.drop && n >= r + 3);
         exit_valid_i   = 1'b0;
         exit_code_i    = $urandom;
         if (n < r) begin
            exit_valid_i = ($urandom_range(0, 3) == 0);
         end else if (n == r + s.k) begin
            exit_valid_i = 1'b1;
            exit_code_i  = s.code;
         end else if (s.late_pulse && n == d + 1) begin
            exit_valid_i = 1'b1;
            exit_code_i  = 32'h5;
         end else if (n >= d) begin
            exit_valid_i = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
      end
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_core_fetch_en", core_fetch_en_o, 0);
      chk("arst_start", start_o, 0);
      chk("arst_done", done_o, 0);
      chk("arst_timeout", timeout_o, 0);
      chk("arst_exit_code", exit_code_o, 0);
      chk("arst_cycle_cnt", cycle_cnt_o, 0);
   endtask

   initial begin
      //            f    k    code           drop dbl lp  R    cnt to xcode
      tbl.push_back(mk(6,   30,  32'h0000_1234, 0,   0,  0,  17,  31, 0, 32'h0000_1234));
      tbl.push_back(mk(1,   49,  32'h0000_0000, 0,   0,  0,  17,  50, 0, 32'h0000_0000));
      tbl.push_back(mk(10,  999, 32'h0000_0077, 0,   0,  0,  17,  64, 1, 32'hFFFF_FFFF));
      tbl.push_back(mk(30,  63,  32'h0000_002A, 0,   0,  0,  32,  64, 0, 32'h0000_002A));
      tbl.push_back(mk(3,   20,  32'h0000_0077, 1,   0,  1,  17,  21, 0, 32'h0000_0077));
      tbl.push_back(mk(101, 5,   32'h0000_0009, 0,   1,  1,  103, 6,  0, 32'h0000_0009));
      tbl.push_back(mk(1,   0,   32'h0000_ABCD, 1,   1,  1,  17,  1,  0, 32'h0000_ABCD));
      tbl.push_back(mk(16,  62,  32'hDEAD_BEEF, 0,   0,  1,  18,  63, 0, 32'hDEAD_BEEF));
      for (int i = 0; i < 24; i++) begin
         tbl.push_back(model($urandom_range(1, 40), $urandom_range(0, 80), $urandom,
                             1'($urandom_range(0, 1)), (i % 6) == 0, 1'b1));
      end
      foreach (tbl[i]) run(tbl[i]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
